// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Architectural fetch-PC register and next-PC control for one core.
//            Presents the PC to instruction fetch with a valid/ready
//            handshake and time-shares a single external 32-bit adder
//            between sequential increment (PC + INSTR_BYTES) and redirect
//            target computation (base + offset).
//            Per-cycle priority: redirect > halt > stall > increment.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_VECTOR    PC loaded on reset
//   INSTR_BYTES     sequential increment (power of two, 1..4)
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           asynchronous active-low reset
//   add_a/add_b     adder operands (combinational from state/registers)
//   add_cin         adder carry-in, tied to 0
//   add_y/add_cout  adder sum / carry-out, same-cycle combinational return
//   redir_valid     redirect request qualifier (single cycle)
//   redir_base      redirect base
//   redir_offset    redirect offset, two's complement
//   stall           hold PC and suppress fetch
//   halt            stop fetching until the next redirect
//   fetch_valid     fetch request valid this cycle
//   fetch_ready     fetch accepted this cycle
//   fetch_pc        address of requested instruction (the PC register)
//   pc_wrap         sticky: a sequential increment carried out of bit 31
//   redir_misalign  one-cycle pulse: redirect target low bits were nonzero
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          INSTR_BYTES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_y,
  input  logic        add_cout,
  input  logic        redir_valid,
  input  logic [31:0] redir_base,
  input  logic [31:0] redir_offset,
  input  logic        stall,
  input  logic        halt,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic        pc_wrap,
  output logic        redir_misalign
);

  // Sequential increment and the mask of PC bits that must be zero for an
  // instruction-aligned address (empty when INSTR_BYTES == 1).
  localparam logic [31:0] c_INC      = 32'(INSTR_BYTES);
  localparam logic [31:0] c_LOW_MASK = 32'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_REDIR  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_base;
  logic [31:0] r_offset;
  logic        r_pc_wrap;
  logic        r_misalign;

  // Next-state / combinational values
  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_base_nxt;
  logic [31:0] w_offset_nxt;
  logic        w_pc_wrap_nxt;
  logic        w_misalign_nxt;
  logic        w_fetch_valid;
  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic [31:0] w_target_low;

  // Low bits of the redirect sum that alignment will discard.
  assign w_target_low = add_y & c_LOW_MASK;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_base_nxt     = r_base;
    w_offset_nxt   = r_offset;
    w_pc_wrap_nxt  = r_pc_wrap;
    w_misalign_nxt = 1'b0;
    w_fetch_valid  = 1'b0;
    // The adder increments the PC unless a redirect target is being formed.
    w_add_a        = r_pc;
    w_add_b        = c_INC;

    case (r_state)
      S_BOOT: begin
        // One dead cycle after reset release before the first fetch.
        w_state_nxt = S_RUN;
      end

      S_RUN: begin
        w_fetch_valid = !stall && !redir_valid && !halt;
        if (redir_valid) begin
          // A concurrent fetch_ready is not a transfer: fetch_valid is low.
          w_base_nxt   = redir_base;
          w_offset_nxt = redir_offset;
          w_state_nxt  = S_REDIR;
        end else if (halt) begin
          w_state_nxt = S_HALTED;
        end else if (!stall && fetch_ready) begin
          w_pc_nxt = add_y;
          if (add_cout) begin
            w_pc_wrap_nxt = 1'b1;
          end
        end
      end

      S_REDIR: begin
        w_add_a = r_base;
        w_add_b = r_offset;
        if (redir_valid) begin
          // Newest redirect wins; the target being formed now is dropped.
          w_base_nxt   = redir_base;
          w_offset_nxt = redir_offset;
        end else begin
          // Target wraps mod 2^32; carry-out deliberately ignored here.
          w_pc_nxt       = add_y & ~c_LOW_MASK;
          w_misalign_nxt = |w_target_low;
          w_state_nxt    = S_RUN;
        end
      end

      S_HALTED: begin
        // Only a redirect leaves HALTED; stall is irrelevant here.
        if (redir_valid) begin
          w_base_nxt   = redir_base;
          w_offset_nxt = redir_offset;
          w_state_nxt  = S_REDIR;
        end
      end

      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VECTOR;
      r_base     <= 32'h0000_0000;
      r_offset   <= 32'h0000_0000;
      r_pc_wrap  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_base     <= w_base_nxt;
      r_offset   <= w_offset_nxt;
      r_pc_wrap  <= w_pc_wrap_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign add_a          = w_add_a;
  assign add_b          = w_add_b;
  assign add_cin        = 1'b0;
  assign fetch_valid    = w_fetch_valid;
  assign fetch_pc       = r_pc;
  assign pc_wrap        = r_pc_wrap;
  assign redir_misalign = r_misalign;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter register and next-PC control for one core of the dual-core processor, sitting directly upstream of and around the 32-bit Brent-Kung adder in the PC updater. It holds the architectural fetch PC and presents it to instruction fetch with a valid/ready handshake. It drives the adder's operands and consumes its sum, time-sharing the single adder between sequential increment (PC + 4) and branch/jump target computation (base + offset). It also handles stall, halt and redirect priority.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment; must be a power of two, at most 4.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- add_a  out  32  adder operand A (combinational from state/registers)
- add_b  out  32  adder operand B
- add_cin  out  1  adder carry-in; always 0
- add_y  in  32  adder sum, same-cycle combinational return
- add_cout  in  1  adder carry-out
- redir_valid  in  1  redirect request, single-cycle qualifier
- redir_base  in  32  redirect base (PC or register value)
- redir_offset  in  32  redirect offset, two's complement
- stall  in  1  hold PC, suppress fetch
- halt  in  1  stop fetching until next redirect
- fetch_valid  out  1  fetch request valid this cycle
- fetch_ready  in  1  fetch accepted this cycle
- fetch_pc  out  32  address of requested instruction (= PC register)
- pc_wrap  out  1  sticky: sequential increment carried out of bit 31
- redir_misalign  out  1  one-cycle pulse: redirect target low bits were nonzero

## Operation
- States: BOOT, RUN, REDIR, HALTED. Registers: pc, base_r, offset_r, pc_wrap, redir_misalign.
- Reset (async assert): pc=RESET_VECTOR, state=BOOT, base_r=offset_r=0, pc_wrap=0, redir_misalign=0. fetch_valid=0, fetch_pc=RESET_VECTOR.
- BOOT: fetch_valid=0; the next edge goes to RUN unconditionally (one dead cycle after reset release).
- RUN: add_a=pc, add_b=INSTR_BYTES, add_cin=0. fetch_valid = !stall && !redir_valid && !halt.
  - Priority per cycle: redir_valid > halt > stall > increment.
  - redir_valid: latch base_r/offset_r and go to REDIR. Any concurrent fetch_ready is ignored and pc is unchanged.
  - halt (no redirect): go to HALTED with pc unchanged.
  - stall: pc holds.
  - fetch_valid && fetch_ready: pc<=add_y. If add_cout=1, set pc_wrap (sticky until reset).
  - fetch_valid && !fetch_ready: pc holds and fetch_valid stays asserted.
- REDIR: add_a=base_r, add_b=offset_r, add_cin=0, fetch_valid=0.
  - pc<=add_y with bits[log2(INSTR_BYTES)-1:0] forced to 0. The sum wraps mod 2^32 and add_cout is ignored (no pc_wrap).
  - redir_misalign<=1 for one cycle if the cleared bits were nonzero.
  - Next state is RUN.
  - redir_valid during REDIR: relatch base_r/offset_r and stay in REDIR; the newest request wins and the old target is discarded.
- HALTED: fetch_valid=0 and pc holds. Adder operands are the same as in RUN but unused. Only redir_valid exits, going to REDIR; stall is ignored.
- The fetch handshake is per-cycle, not sticky. Redirect, halt or stall may withdraw fetch_valid without a completed transfer. The consumer treats only a valid&&ready cycle as a transfer.

## Timing
- Sequential throughput: one PC per cycle while fetch_ready=1 and there is no stall.
- Redirect latency: request in cycle N, REDIR in N+1, fetch_valid=1 with fetch_pc=target in N+2 (absent stall, halt or another redirect).
- Adder path is combinational in one cycle (add_a/b -> add_y -> pc D input). There are no registered adder operands.
- Reset assertion mid-REDIR drops the pending target. The first fetch after release is at RESET_VECTOR, two edges after rst_n rises.
- All outputs except add_* and fetch_valid are registered. fetch_valid depends combinationally on stall, halt and redir_valid.

## Test plan
- Reset release with fetch_ready=1: the cycle after BOOT, fetch_pc=0x0, then 0x4, 0x8, 0xC on consecutive cycles.
- fetch_ready low for 3 cycles at pc=0x10: fetch_valid stays 1 and fetch_pc holds 0x10. When ready rises, 0x14 follows.
- redir_valid with base=0x100, offset=0xFFFF_FFF0 while fetch_ready=1: two cycles later fetch_pc=0xF0. The concurrent fetch is not counted and pc_wrap stays 0.
- Back-to-back redirects (0x200+0x4, then 0x300+0x8) on consecutive cycles: only 0x308 is fetched. A third redirect with offset 0x2 gives fetch_pc=0x308+0x0 (low bits cleared, to 0x30A&~3) and a one-cycle redir_misalign pulse.
- pc=0xFFFF_FFFC, accepted fetch: pc becomes 0x0 and pc_wrap=1, persisting until rst_n is asserted.
- halt and stall together with redir_valid: redirect taken. Halt alone: fetch_valid=0 indefinitely until a redirect, then a fetch at the target two cycles later.
